// File: rtl/countdown_timer8.sv
// countdown_timer8: loadable down counter with terminal-count pulse.
// Define COUNTDOWN_AUTORELOAD_EN to reload the last loaded value at terminal count.
module countdown_timer8 #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    output logic [WIDTH-1:0] Q,
    output logic             zero,
    output logic             tc_pulse,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state;
`ifdef COUNTDOWN_AUTORELOAD_EN
    logic [WIDTH-1:0] reload;
`endif
    assign zero = (Q == '0);
    assign busy = (state == RUN);
    // RUN always holds a nonzero Q, so only Q==1 can reach the terminal event
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            Q        <= '0;
            state    <= IDLE;
            tc_pulse <= 1'b0;
`ifdef COUNTDOWN_AUTORELOAD_EN
            reload   <= '0;
`endif
        end else if (load) begin
            Q        <= load_value;
            state    <= (load_value != '0) ? RUN : DONE;
            tc_pulse <= 1'b0;
`ifdef COUNTDOWN_AUTORELOAD_EN
            reload   <= load_value;
`endif
        end else if (state == RUN && enable) begin
            if (Q == WIDTH'(1)) begin
`ifdef COUNTDOWN_AUTORELOAD_EN
                Q     <= reload;
`else
                Q     <= '0;
                state <= DONE;
`endif
                tc_pulse <= 1'b1;
            end else begin
                Q        <= Q - WIDTH'(1);
                tc_pulse <= 1'b0;
            end
        end else begin
            tc_pulse <= 1'b0;
        end
    end
endmodule
